// File: rtl/operand_issue.sv
// operand_issue: decode/issue stage feeding the ALU operand-select interface.
// Reads the register file combinationally, applies writeback forwarding and
// registers one issued operation behind a valid/ready handshake. A HALT
// instruction parks the stage until a flush or reset.
module operand_issue #(
    parameter int unsigned REG_DATA_WIDTH = 16,
    parameter int unsigned DATA_2_WIDTH   = 4,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned INSTR_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    instr,
    input  logic                      flush,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_1,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_2,
    input  logic [REG_DATA_WIDTH-1:0] rf_data_1,
    input  logic [REG_DATA_WIDTH-1:0] rf_data_2,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [REG_DATA_WIDTH-1:0] wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_DATA_WIDTH-1:0] out_data_1,
    output logic [REG_DATA_WIDTH-1:0] out_reg_2,
    output logic [DATA_2_WIDTH-1:0]   out_imm,
    output logic                      out_alu_src,
    output logic [3:0]                out_alu_op,
    output logic [REG_ADDR_WIDTH-1:0] out_dest,
    output logic                      out_reg_write,
    output logic                      out_illegal,
    output logic                      halted
);

    localparam int unsigned OP_WIDTH = 4;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned RS_LSB   = 4;
    localparam int unsigned RT_LSB   = 0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic                      ready_int;
    logic                      accept;
    logic [OP_WIDTH-1:0]       opcode;
    logic                      dec_alu_src;
    logic                      dec_reg_write;
    logic                      dec_illegal;
    logic                      dec_halt;
    logic [REG_DATA_WIDTH-1:0] fwd_data_1;
    logic [REG_DATA_WIDTH-1:0] fwd_data_2;

    // Instruction field extraction and register file read addresses
    assign opcode    = instr[OP_LSB +: OP_WIDTH];
    assign rf_addr_1 = instr[RS_LSB +: REG_ADDR_WIDTH];
    assign rf_addr_2 = instr[RT_LSB +: REG_ADDR_WIDTH];
    assign in_ready  = ready_int;
    assign accept    = in_valid & ready_int;

    // Opcode decode into operand-select, writeback and exception flags
    always_comb begin
        dec_alu_src   = 1'b0;
        dec_reg_write = 1'b0;
        dec_illegal   = 1'b0;
        dec_halt      = 1'b0;
        case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4: begin
                dec_reg_write = 1'b1;
            end
            4'h5, 4'h6, 4'h7, 4'h8: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                dec_illegal   = 1'b1;
            end
            4'hF: begin
                dec_halt      = 1'b1;
            end
            default: begin
                dec_alu_src   = 1'b0;
            end
        endcase
    end

    // Writeback bypass: a same-cycle write wins over the stale regfile read
    always_comb begin
        fwd_data_1 = rf_data_1;
        fwd_data_2 = rf_data_2;
        if (wb_en && (wb_addr == rf_addr_1)) begin
            fwd_data_1 = wb_data;
        end
        if (wb_en && (wb_addr == rf_addr_2)) begin
            fwd_data_2 = wb_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and input handshake; flush always returns to RUN
    always_comb begin
        state_d   = state_q;
        ready_int = 1'b0;
        case (state_q)
            ST_RUN: begin
                ready_int = ~flush & (~out_valid | out_ready);
                if (in_valid && ready_int && dec_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                ready_int = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (flush) begin
            state_d = ST_RUN;
        end
    end

    // Issue register: load on accept, clear on drain or flush, hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data_1    <= '0;
            out_reg_2     <= '0;
            out_imm       <= '0;
            out_alu_src   <= 1'b0;
            out_alu_op    <= '0;
            out_dest      <= '0;
            out_reg_write <= 1'b0;
            out_illegal   <= 1'b0;
            halted        <= 1'b0;
        end else begin
            halted <= (state_d == ST_HALTED);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                if (dec_halt) begin
                    // HALT is consumed without producing an operation
                    out_valid <= 1'b0;
                end else begin
                    out_valid     <= 1'b1;
                    out_data_1    <= fwd_data_1;
                    out_reg_2     <= fwd_data_2;
                    out_imm       <= instr[RT_LSB +: DATA_2_WIDTH];
                    out_alu_src   <= dec_alu_src;
                    out_alu_op    <= opcode;
                    out_dest      <= instr[RD_LSB +: REG_ADDR_WIDTH];
                    out_reg_write <= dec_reg_write;
                    out_illegal   <= dec_illegal;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
